// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 16:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned NUM_CH   = 16;
    localparam int unsigned SEL_LO_W = 2;
    localparam int unsigned SEL_HI_W = 2;
    localparam int unsigned DWELL_W  = 4;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHAN   = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable down-counter timing the settle interval; o_last_c flags the final settle cycle.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_last_c
);

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign o_last_c = (r_count == DWELL_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the select lines of a 16:1 mux, sampling each enabled channel after a settle time.
// Optional MUX_SCAN_PARITY_EN adds a registered parity output (XOR of result) updated with done.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CH_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_CH-1:0]   chan_mask,
    input  logic                mux_out,
    output logic [SEL_LO_W-1:0] s1,
    output logic [SEL_HI_W-1:0] s2,
    output logic                busy,
    output logic                done,
    output logic [NUM_CH-1:0]   result,
    output logic [CNT_W-1:0]    sample_cnt
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                parity
`endif
);

    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_result;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [NUM_CH-1:0]   w_result_nxt;
    logic                w_ch_en;
    logic                w_advance;
    logic                w_last;
`ifdef MUX_SCAN_PARITY_EN
    logic                r_parity;
`endif

    assign w_ch_en   = r_mask[r_ch];
    assign w_advance = ((r_state == CHAN) && !w_ch_en) || (r_state == SAMPLE);

    // Result as it will look after the current channel retires.
    always_comb begin
        w_result_nxt       = r_result;
        w_result_nxt[r_ch] = (r_state == SAMPLE) ? mux_out : 1'b0;
    end

    mux_scan_dwell_cnt u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_load     ((r_state == CHAN) && w_ch_en),
        .i_load_val (DWELL_W'(DWELL)),
        .i_dec      (r_state == SETTLE),
        .o_last_c   (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ch     <= '0;
            r_mask   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_advance) begin
                r_result <= w_result_nxt;
                if (r_state == SAMPLE) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (r_ch == CH_W'(NUM_CH - 1)) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    r_parity <= ^w_result_nxt;
`endif
                end else begin
                    r_ch    <= r_ch + CH_W'(1);
                    r_state <= CHAN;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_mask   <= chan_mask;
                            r_result <= '0;
                            r_cnt    <= '0;
                            r_ch     <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= CHAN;
                        end
                    end
                    CHAN: begin
                        // Only enabled channels reach here; zero dwell skips SETTLE.
                        r_state <= (DWELL == 0) ? SAMPLE : SETTLE;
                    end
                    SETTLE: begin
                        if (w_last) begin
                            r_state <= SAMPLE;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign s1         = r_ch[SEL_LO_W-1:0];
    assign s2         = r_ch[SEL_LO_W+SEL_HI_W-1:SEL_LO_W];
    assign busy       = r_busy;
    assign done       = r_done;
    assign result     = r_result;
    assign sample_cnt = r_cnt;
`ifdef MUX_SCAN_PARITY_EN
    assign parity     = r_parity;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two controllers (DWELL=2 and DWELL=0), each driving a 16:1 mux model.
module tb_mux_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] chan_mask;
    logic [15:0] mux_in;

    logic [1:0]  s1_2, s2_2, s1_0, s2_0;
    logic        busy2, done2, busy0, done0;
    logic [15:0] result2, result0;
    logic [4:0]  cnt2, cnt0;
    logic        mux_out2, mux_out0;
`ifdef MUX_SCAN_PARITY_EN
    logic        par2, par0;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] sel_log [64];

    assign mux_out2 = mux_in[{s2_2, s1_2}];
    assign mux_out0 = mux_in[{s2_0, s1_0}];

    mux_scan_ctrl #(.DWELL(2), .CH_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask), .mux_out(mux_out2),
        .s1(s1_2), .s2(s2_2), .busy(busy2), .done(done2), .result(result2), .sample_cnt(cnt2)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par2)
`endif
    );

    mux_scan_ctrl #(.DWELL(0), .CH_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask), .mux_out(mux_out0),
        .s1(s1_0), .s2(s2_0), .busy(busy0), .done(done0), .result(result0), .sample_cnt(cnt0)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par0)
`endif
    );

    always #5 clk = ~clk;

    // Waits for both controllers to be idle, launches one scan and measures it.
    task automatic run_scan(input bit use_d0, input logic [15:0] mask_after, input int pulse_at,
                            output int busy_n, output int done_n, output bit par_done, output bit to);
        int  n;
        bit  b, d, after_done;
        busy_n = 0; done_n = 0; par_done = 1'b0; to = 1'b0; n = 0; after_done = 1'b0;
        @(negedge clk);
        while (busy0 || busy2 || done0 || done2) begin
            n++;
            if (n > 300) begin to = 1'b1; return; end
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chan_mask = mask_after;
        n = 0;
        forever begin
            b = use_d0 ? busy0 : busy2;
            d = use_d0 ? done0 : done2;
            if (b) begin
                if (busy_n < 64) sel_log[busy_n] = use_d0 ? {s2_0, s1_0} : {s2_2, s1_2};
                busy_n++;
            end
            if (d) begin
                done_n++;
`ifdef MUX_SCAN_PARITY_EN
                par_done = use_d0 ? par0 : par2;
`endif
            end
            start = (pulse_at >= 0) && b && (busy_n == pulse_at);
            if (after_done) break;
            after_done = (done_n > 0);
            n++;
            if (n > 400) begin to = 1'b1; break; end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        checks++;
        if ({s2_2, s1_2, busy2, done2, result2, cnt2} !== 29'd0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", {s2_2, s1_2, busy2, done2, result2, cnt2});
        end
        chan_mask = 16'hFFFF; mux_in = 16'hFFFF;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (k = 0; k < 20; k++) @(negedge clk);
        checks++;
        if (busy2 !== 1'b1 || result2 === 16'h0) begin
            errors++;
            $display("FAIL reset_prescan: busy=%b result=%h expected busy=1 result nonzero", busy2, result2);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s2_2, s1_2, busy2, done2, result2, cnt2} !== 29'd0) begin
            errors++;
            $display("FAIL reset_async_dut2: got %h expected 0", {s2_2, s1_2, busy2, done2, result2, cnt2});
        end
        checks++;
        if ({s2_0, s1_0, busy0, done0, result0, cnt0} !== 29'd0) begin
            errors++;
            $display("FAIL reset_async_dut0: got %h expected 0", {s2_0, s1_0, busy0, done0, result0, cnt0});
        end
        @(negedge clk); rst = 1'b0;
        k = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy2 || done2 || busy0 || done0) k++;
        end
        checks++;
        if (k !== 0) begin
            errors++;
            $display("FAIL reset_release_idle: active cycles=%0d expected 0", k);
        end
    endtask

    task automatic test_full_scan();
        int bn, dn, bad;
        bit p, to;
        chan_mask = 16'hFFFF; mux_in = 16'hA5C3;
        run_scan(1'b0, 16'hFFFF, -1, bn, dn, p, to);
        checks++;
        if (to || bn !== 64 || dn !== 1) begin
            errors++;
            $display("FAIL full_timing: busy=%0d done=%0d to=%0b expected busy=64 done=1", bn, dn, to);
        end
        checks++;
        if (result2 !== 16'hA5C3 || cnt2 !== 5'd16) begin
            errors++;
            $display("FAIL full_result: result=%h cnt=%0d expected a5c3 cnt=16", result2, cnt2);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (sel_log[i] !== 4'(i / 4)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_sel_hold: bad cycles=%0d expected 0", bad);
        end
        checks++;
        if ({s2_2, s1_2} !== 4'hF || result0 !== 16'hA5C3) begin
            errors++;
            $display("FAIL full_hold: sel=%h result0=%h expected sel=f result0=a5c3", {s2_2, s1_2}, result0);
        end
    endtask

    task automatic test_masked_scan();
        int bn, dn;
        bit p, to;
        chan_mask = 16'h0101; mux_in = 16'hFFFF;
        run_scan(1'b0, 16'h0101, -1, bn, dn, p, to);
        checks++;
        if (to || bn !== 22 || dn !== 1 || result2 !== 16'h0101 || cnt2 !== 5'd2) begin
            errors++;
            $display("FAIL masked_0101: busy=%0d done=%0d result=%h cnt=%0d expected 22 1 0101 2", bn, dn, result2, cnt2);
        end
        chan_mask = 16'h0000;
        run_scan(1'b0, 16'h0000, -1, bn, dn, p, to);
        checks++;
        if (to || bn !== 16 || dn !== 1 || result2 !== 16'h0000 || cnt2 !== 5'd0) begin
            errors++;
            $display("FAIL masked_zero: busy=%0d done=%0d result=%h cnt=%0d expected 16 1 0000 0", bn, dn, result2, cnt2);
        end
    endtask

    task automatic test_dwell0();
        int bn, dn;
        bit p, to;
        chan_mask = 16'hFFFF; mux_in = 16'h1234;
        run_scan(1'b1, 16'hFFFF, -1, bn, dn, p, to);
        checks++;
        if (to || bn !== 32 || dn !== 1) begin
            errors++;
            $display("FAIL dwell0_timing: busy=%0d done=%0d expected 32 1", bn, dn);
        end
        checks++;
        if (result0 !== 16'h1234 || cnt0 !== 5'd16) begin
            errors++;
            $display("FAIL dwell0_result: result=%h cnt=%0d expected 1234 16", result0, cnt0);
        end
    endtask

    task automatic test_start_ignored();
        int bn, dn;
        bit p, to;
        chan_mask = 16'hFFFF; mux_in = 16'h3C96;
        run_scan(1'b0, 16'h0000, 10, bn, dn, p, to);
        checks++;
        if (to || bn !== 64 || dn !== 1) begin
            errors++;
            $display("FAIL ignored_timing: busy=%0d done=%0d expected 64 1", bn, dn);
        end
        checks++;
        if (result2 !== 16'h3C96 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL ignored_result: result=%h busy=%b expected 3c96 0", result2, busy2);
        end
    endtask

    task automatic test_back_to_back();
        int n, first, second, nd;
        chan_mask = 16'h0000; mux_in = 16'hFFFF;
        n = 0; first = -1; second = -1; nd = 0;
        @(negedge clk);
        while (busy0 || busy2 || done0 || done2) begin
            n++;
            if (n > 300) break;
            @(negedge clk);
        end
        start = 1'b1;
        n = 0;
        while (n < 200 && second < 0) begin
            @(negedge clk);
            n++;
            if (done2) begin
                nd++;
                if (first < 0) first = n; else second = n;
            end
        end
        start = 1'b0;
        checks++;
        if (second - first !== 18 || nd !== 2) begin
            errors++;
            $display("FAIL back_to_back: gap=%0d dones=%0d expected gap=18 dones=2", second - first, nd);
        end
    endtask

    task automatic test_abort();
        int bn, dn, k, nd;
        bit p, to;
        chan_mask = 16'hFFFF; mux_in = 16'hFFFF;
        k = 0; nd = 0;
        @(negedge clk);
        while ((busy0 || busy2 || done0 || done2) && k < 300) begin k++; @(negedge clk); end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (busy2 && k < 20) begin
            if (done2) nd++;
            k++;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (k !== 20 || {s2_2, s1_2, busy2, done2, result2, cnt2} !== 29'd0) begin
            errors++;
            $display("FAIL abort_reset: cycles=%0d state=%h expected 20 and 0", k, {s2_2, s1_2, busy2, done2, result2, cnt2});
        end
        @(negedge clk); rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done2 || done0 || busy2 || busy0) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: activity=%0d expected 0", nd);
        end
        mux_in = 16'h5A3C;
        run_scan(1'b0, 16'hFFFF, -1, bn, dn, p, to);
        checks++;
        if (to || bn !== 64 || dn !== 1 || result2 !== 16'h5A3C || cnt2 !== 5'd16) begin
            errors++;
            $display("FAIL abort_clean_scan: busy=%0d done=%0d result=%h cnt=%0d expected 64 1 5a3c 16", bn, dn, result2, cnt2);
        end
    endtask

    task automatic test_parity();
`ifdef MUX_SCAN_PARITY_EN
        int bn, dn;
        bit p, to;
        chan_mask = 16'hFFFF; mux_in = 16'h0007;
        run_scan(1'b0, 16'hFFFF, -1, bn, dn, p, to);
        checks++;
        if (to || p !== 1'b1) begin
            errors++;
            $display("FAIL parity_odd: got %b expected 1", p);
        end
        mux_in = 16'h0003;
        run_scan(1'b0, 16'hFFFF, -1, bn, dn, p, to);
        checks++;
        if (to || p !== 1'b0 || par2 !== 1'b0) begin
            errors++;
            $display("FAIL parity_even: got %b held %b expected 0", p, par2);
        end
`endif
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; chan_mask = 16'h0; mux_in = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_masked_scan();
        test_dwell0();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
